// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction buffer between fetch and decode. Valid/ready
//               FIFO carrying pc, instruction word and predicted-taken bit,
//               with first-word fall-through and a one-cycle flush. An empty
//               queue presents a canonical NOP to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [XLEN-1:0]            i_enq_pc,
    input  logic [XLEN-1:0]            i_enq_instr,
    input  logic                       i_enq_pred_taken,
    output logic                       o_deq_valid,
    input  logic                       i_deq_ready,
    output logic [XLEN-1:0]            o_deq_pc,
    output logic [XLEN-1:0]            o_deq_instr,
    output logic                       o_deq_pred_taken,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int              c_AW  = $clog2(DEPTH);
    localparam int              c_PW  = c_AW + 1;
    localparam int              c_CW  = $clog2(DEPTH+1);
    // addi x0,x0,0 - decode sees a harmless instruction when nothing is queued
    localparam logic [XLEN-1:0] c_NOP = XLEN'(32'h0000_0013);

    // Storage array; contents are qualified by the pointers so no reset.
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic            r_pred_mem  [DEPTH];

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [c_AW-1:0] w_wr_idx;
    logic [c_AW-1:0] w_rd_idx;
    logic            w_empty;
    logic            w_full;
    logic            w_enq_fire;
    logic            w_deq_fire;

    assign w_wr_idx = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];

    // Equal pointers mean empty; equal index with differing wrap bit means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

    // Flush discards both handshakes of its cycle. Enqueue ready depends only
    // on registered state, so a full queue refuses even with a dequeue pending.
    assign w_enq_fire = i_enq_valid && !w_full && !i_flush;
    assign w_deq_fire = i_deq_ready && !w_empty && !i_flush;

    assign o_enq_ready = !w_full;
    assign o_deq_valid = !w_empty;
    assign o_count     = r_count;

    // Head fields fall through from the array; empty queue shows a NOP.
    always_comb begin
        o_deq_pc         = '0;
        o_deq_instr      = c_NOP;
        o_deq_pred_taken = 1'b0;
        if (!w_empty) begin
            o_deq_pc         = r_pc_mem[w_rd_idx];
            o_deq_instr      = r_instr_mem[w_rd_idx];
            o_deq_pred_taken = r_pred_mem[w_rd_idx];
        end
    end

    // Write the accepted fetch entry into the slot at the write index.
    always_ff @(posedge i_clk) begin
        if (w_enq_fire) begin
            r_pc_mem[w_wr_idx]    <= i_enq_pc;
            r_instr_mem[w_wr_idx] <= i_enq_instr;
            r_pred_mem[w_wr_idx]  <= i_enq_pred_taken;
        end
    end

    // Pointer and occupancy tracking; flush returns everything to index 0.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_enq_fire && !w_deq_fire) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_deq_fire && !w_enq_fire) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Scoreboard bench for fetch_queue. Stimulus pushes expected
//               entries as they are accepted; a monitor pops and compares on
//               every dequeue handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pt;
    } ent_t;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_enq_valid = 1'b0;
    logic            o_enq_ready;
    logic [XLEN-1:0] i_enq_pc = '0;
    logic [XLEN-1:0] i_enq_instr = '0;
    logic            i_enq_pred_taken = 1'b0;
    logic            o_deq_valid;
    logic            i_deq_ready = 1'b0;
    logic [XLEN-1:0] o_deq_pc;
    logic [XLEN-1:0] o_deq_instr;
    logic            o_deq_pred_taken;
    logic            i_flush = 1'b0;
    logic [CW-1:0]   o_count;

    ent_t sb[$];
    int   mdl_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_enq_valid      (i_enq_valid),
        .o_enq_ready      (o_enq_ready),
        .i_enq_pc         (i_enq_pc),
        .i_enq_instr      (i_enq_instr),
        .i_enq_pred_taken (i_enq_pred_taken),
        .o_deq_valid      (o_deq_valid),
        .i_deq_ready      (i_deq_ready),
        .o_deq_pc         (o_deq_pc),
        .o_deq_instr      (o_deq_instr),
        .o_deq_pred_taken (o_deq_pred_taken),
        .i_flush          (i_flush),
        .o_count          (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every dequeue handshake must match the oldest expected entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset && o_deq_valid && i_deq_ready && !i_flush) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: dequeue of pc 0x%08h with no expected entry", o_deq_pc);
                end else begin
                    e = sb.pop_front();
                    chk("deq_pc",    o_deq_pc,                e.pc);
                    chk("deq_instr", o_deq_instr,             e.instr);
                    chk("deq_pred",  32'(o_deq_pred_taken),   32'(e.pt));
                end
            end
        end
    end

    // One clock cycle of stimulus; checks status outputs against the model
    // mid-cycle and updates the model at the edge.
    task automatic cyc(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pt, input logic dr, input logic fl);
        logic acc_e;
        logic acc_d;
        i_enq_valid      = ev;
        i_enq_pc         = pc;
        i_enq_instr      = ins;
        i_enq_pred_taken = pt;
        i_deq_ready      = dr;
        i_flush          = fl;
        @(negedge i_clk);
        chk("count",     32'(o_count),     32'(mdl_cnt));
        chk("enq_ready", 32'(o_enq_ready), 32'(mdl_cnt != DEPTH));
        chk("deq_valid", 32'(o_deq_valid), 32'(mdl_cnt != 0));
        if (mdl_cnt == 0) begin
            chk("nop_pc",    o_deq_pc,                32'h0);
            chk("nop_instr", o_deq_instr,             32'h0000_0013);
            chk("nop_pred",  32'(o_deq_pred_taken),   32'h0);
        end
        acc_e = ev && (mdl_cnt != DEPTH) && !fl;
        acc_d = dr && (mdl_cnt != 0) && !fl;
        @(posedge i_clk);
        if (fl) begin
            sb.delete();
            mdl_cnt = 0;
        end else begin
            if (acc_e) sb.push_back('{pc: pc, instr: ins, pt: pt});
            mdl_cnt = mdl_cnt + int'(acc_e) - int'(acc_d);
        end
        #1;
        i_enq_valid = 1'b0;
        i_deq_ready = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1;
        idle();
        idle();

        // Single enqueue, head visible next cycle without bypass
        cyc(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0);
        chk("head_pc",    o_deq_pc,              32'h100);
        chk("head_instr", o_deq_instr,           32'h0050_0093);
        chk("head_pred",  32'(o_deq_pred_taken), 32'h1);
        chk("head_count", 32'(o_count),          32'h1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // Fill to full, refused fifth enqueue, full with dequeue refuses enqueue
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'(i*4), 32'h0000_0013 | 32'(i << 20), 1'(i & 1), 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD, 32'hBAD0_0BAD, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hBEEF, 32'hBAD1_1BAD, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // Streaming: two queued, then ten cycles of enqueue+dequeue
        cyc(1'b1, 32'h1000, 32'h0010_0113, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1004, 32'h0020_0113, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 32'h1008 + 32'(i*4), 32'h0030_0113 + 32'(i << 7), 1'(i % 3 == 0), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // Flush with three queued and both handshakes presented
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h300 + 32'(i*4), 32'h00A0_0513 + 32'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h3FC, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
        chk("flush_count", 32'(o_count), 32'h0);
        chk("flush_instr", o_deq_instr,  32'h0000_0013);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h200, 32'h0070_0393, 1'b0, 1'b0, 1'b0);
        chk("post_flush_pc",    o_deq_pc,    32'h200);
        chk("post_flush_instr", o_deq_instr, 32'h0070_0393);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges with two queued
        cyc(1'b1, 32'h500, 32'h0080_0413, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 32'h0090_0493, 1'b0, 1'b0, 1'b0);
        #1 i_reset = 1'b0;
        #1;
        chk("rst_valid", 32'(o_deq_valid),      32'h0);
        chk("rst_ready", 32'(o_enq_ready),      32'h1);
        chk("rst_count", 32'(o_count),          32'h0);
        chk("rst_pc",    o_deq_pc,              32'h0);
        chk("rst_instr", o_deq_instr,           32'h0000_0013);
        chk("rst_pred",  32'(o_deq_pred_taken), 32'h0);
        #1 i_reset = 1'b1;
        sb.delete();
        mdl_cnt = 0;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h600, 32'h00B0_0593, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage (I-cache plus gshare predictor) and the decode stage.
- Decoupled valid/ready FIFO on both sides. Each entry carries pc, instruction word and predicted-taken bit.
- The dequeue-side instruction drives the decode stage directly, including the immediate generator. When no valid entry exists, that instruction is a canonical NOP.
- Flushed in one cycle on branch mispredict or redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- XLEN, 32, width of pc and instruction fields

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_reset  input  1  asynchronous active-low reset
- i_enq_valid  input  1  fetch presents an entry
- o_enq_ready  output  1  queue can accept an entry this cycle
- i_enq_pc  input  XLEN  pc of the fetched instruction
- i_enq_instr  input  XLEN  fetched instruction word
- i_enq_pred_taken  input  1  gshare predicted-taken bit for this instruction
- o_deq_valid  output  1  head entry is valid
- i_deq_ready  input  1  decode consumes the head this cycle
- o_deq_pc  output  XLEN  head pc
- o_deq_instr  output  XLEN  head instruction; feeds decode and immediate generation
- o_deq_pred_taken  output  1  head predicted-taken bit
- i_flush  input  1  mispredict or redirect; discard all entries
- o_count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (i_reset=0, asynchronous):
  - read/write pointers and count go to 0.
  - o_deq_valid=0, o_enq_ready=1, o_count=0.
  - o_deq_pc=0, o_deq_instr=32'h00000013, o_deq_pred_taken=0.
  - Storage array contents need no reset.
- Pointers:
  - Width is $clog2(DEPTH)+1; the extra wrap bit distinguishes full from empty.
  - Index is the low $clog2(DEPTH) bits; pointers wrap modulo 2*DEPTH.
- Empty when pointers are equal. Full when indices are equal and wrap bits differ.
- o_enq_ready = !full.
  - Registered-state only; no combinational dependence on i_deq_ready.
  - When full, an enqueue is not accepted even if a dequeue occurs in the same cycle.
- o_deq_valid = !empty. Head fields read combinationally from the storage array (first-word fall-through).
- When empty, dequeue outputs are forced to pc=0, instr=32'h00000013 (addi x0,x0,0), pred_taken=0.
- Enqueue fires when i_enq_valid && o_enq_ready:
  - pc, instr and pred_taken are written to the write index at the clock edge.
  - Write pointer increments.
- Dequeue fires when o_deq_valid && i_deq_ready; read pointer increments.
- Latency: an entry enqueued into an empty queue is visible at the dequeue side on the next cycle. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue, neither full nor empty: both pointers advance and count is unchanged.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Flush (i_flush=1) takes priority over everything in that cycle:
  - at the next edge both pointers and count return to 0.
  - any enqueue and dequeue presented in that cycle are discarded; the storage write is suppressed.
  - outputs in the flush cycle still reflect the pre-flush state.
- Back-to-back flush cycles keep the queue empty.
- The first enqueue accepted after a flush is written to index 0.
- Reset asserted mid-operation clears the queue immediately, regardless of pending handshakes.
- Inputs with i_enq_valid=0 and values on i_deq_ready while empty have no effect on state.

Test Plan:
- Reset then idle → o_deq_valid=0, o_deq_instr=0x00000013, o_count=0, o_enq_ready=1.
- Enqueue pc=0x100, instr=0x00500093, pred=1 with i_deq_ready=0 → next cycle o_deq_valid=1, o_deq_pc=0x100, o_deq_instr=0x00500093, o_deq_pred_taken=1, o_count=1.
- Enqueue 4 entries (pc 0x0,0x4,0x8,0xC) with no dequeue → o_enq_ready=0, o_count=4. A fifth i_enq_valid is ignored. Draining yields pc order 0x0,0x4,0x8,0xC, then o_deq_valid=0.
- Continuous enqueue+dequeue every cycle over 10 entries → o_count stays constant, pointers wrap twice, pc order preserved with no loss or duplication.
- Queue with 3 entries; assert i_flush together with i_enq_valid=1 and i_deq_ready=1 → next cycle o_count=0, o_deq_instr=0x00000013. Next enqueue (pc=0x200) appears as head one cycle later.
- Queue with 2 entries; pulse i_reset low between clock edges → outputs return to reset values immediately, without waiting for a clock edge.
